// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS controller.
// Opcode/funct codes, ALU operation encoding, FSM states, decode bundle.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_LOAD  = 6'b000010;
    localparam logic [5:0] OP_STORE = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_MUL = 6'b110010;

    localparam int MUL_MAX_CYC_DEF = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_MUL = 3'b100
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MULW   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    typedef struct packed {
        logic    is_rtype;
        logic    is_load;
        logic    is_store;
        logic    is_mul;
        logic    illegal;
        alu_op_e alu_op;
    } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/acknowledge port of the multi-cycle controller.
// The controller is master; the memory system answers as slave.
interface multicycle_ctrl_if;

    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ack
    );

endinterface

// File: rtl/multicycle_ctrl_instr_class.sv
// Combinational instruction classifier for the multi-cycle controller.
// Splits the IR into type flags, illegal flag and the ALU operation.
module instr_class
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_t     cls
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign funct       = instr[5:0];
    assign unused_bits = ^instr[25:6];

    // Classify op/funct; anything not recognised is flagged illegal
    always_comb begin
        cls        = '0;
        cls.alu_op = ALU_ADD;
        unique case (1'b1)
            (op == OP_LOAD): begin
                cls.is_load = 1'b1;
            end
            (op == OP_STORE): begin
                cls.is_store = 1'b1;
            end
            (op == OP_RTYPE): begin
                cls.is_rtype = 1'b1;
                unique case (funct)
                    F_ADD: cls.alu_op = ALU_ADD;
                    F_SUB: cls.alu_op = ALU_SUB;
                    F_AND: cls.alu_op = ALU_AND;
                    F_OR:  cls.alu_op = ALU_OR;
                    F_MUL: begin
                        cls.alu_op = ALU_MUL;
                        cls.is_mul = 1'b1;
                    end
                    default: begin
                        cls.is_rtype = 1'b0;
                        cls.illegal  = 1'b1;
                    end
                endcase
            end
            default: begin
                cls.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: fetch, decode, execute, memory, writeback.
// Drives PC/IR/ALU/regfile/memory/multiplier enables per cycle.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MUL_MAX_CYC = MUL_MAX_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic [31:0]       instr,
    input  logic              mul_done,
    multicycle_ctrl_if.master mem,
    output logic              pc_we,
    output logic              ir_we,
    output logic [2:0]        alu_op,
    output logic              alu_src_imm,
    output logic              mul_start,
    output logic              reg_we,
    output logic              reg_dst_rd,
    output logic              wb_sel_mem,
    output logic              busy,
    output logic              illegal,
    output logic              fault,
    output logic [15:0]       instr_cnt,
    output logic [2:0]        state
);

    localparam int MCW = $clog2(MUL_MAX_CYC + 1);
    localparam logic [MCW-1:0] MC_LAST = MCW'(MUL_MAX_CYC - 1);

    state_e         state_q;
    state_e         state_d;
    logic [MCW-1:0] mcnt_q;
    logic [15:0]    cnt_q;
    logic           ill_q;
    logic           fault_q;

    iclass_t        cls;
    logic           ack;
    logic           mul_to;
    logic           retire;
    logic           mem_op;

    alu_op_e        alu_op_d;
    logic           mem_req_d;
    logic           mem_we_d;

    instr_class u_cls (
        .instr (instr),
        .cls   (cls)
    );

    assign ack    = mem.mem_ack;
    assign mem_op = cls.is_load | cls.is_store;
    assign mul_to = (mcnt_q == MC_LAST);

    // A STORE retires on its memory ack; everything else in WB
    assign retire = (state_q == S_WB) ||
                    ((state_q == S_MEM) && cls.is_store && ack);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: step through the instruction, stop in HALT on error
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (ack) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cls.illegal)     state_d = S_HALT;
                else if (cls.is_mul) state_d = S_MULW;
                else                 state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = mem_op ? S_MEM : S_WB;
            end
            S_MULW: begin
                if (mul_done)    state_d = S_WB;
                else if (mul_to) state_d = S_HALT;
            end
            S_MEM: begin
                if (ack) begin
                    if (cls.is_load) state_d = S_WB;
                    else if (run)    state_d = S_FETCH;
                    else             state_d = S_IDLE;
                end
            end
            S_WB: begin
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Per-state strobes; fetch loads IR and bumps PC on the ack cycle
    always_comb begin
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        alu_op_d    = ALU_ADD;
        alu_src_imm = 1'b0;
        mul_start   = 1'b0;
        reg_we      = 1'b0;
        reg_dst_rd  = 1'b0;
        wb_sel_mem  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req_d = 1'b1;
                ir_we     = ack;
                pc_we     = ack;
            end
            S_EXEC: begin
                alu_op_d    = cls.alu_op;
                alu_src_imm = mem_op;
            end
            S_MULW: begin
                alu_op_d  = ALU_MUL;
                mul_start = (mcnt_q == '0);
            end
            S_MEM: begin
                mem_req_d   = 1'b1;
                mem_we_d    = cls.is_store;
                alu_op_d    = ALU_ADD;
                alu_src_imm = 1'b1;
            end
            S_WB: begin
                alu_op_d   = cls.alu_op;
                reg_we     = 1'b1;
                reg_dst_rd = cls.is_rtype;
                wb_sel_mem = cls.is_load;
            end
            default: begin
            end
        endcase
    end

    // Multiply wait counter, retire counter and sticky error flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcnt_q  <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            if (state_q == S_MULW) begin
                mcnt_q <= mcnt_q + MCW'(1);
            end else begin
                mcnt_q <= '0;
            end
            if (retire) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if ((state_q == S_DECODE) && cls.illegal) begin
                ill_q <= 1'b1;
            end
            if ((state_q == S_MULW) && !mul_done && mul_to) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign mem.mem_req = mem_req_d;
    assign mem.mem_we  = mem_we_d;
    assign alu_op      = alu_op_d;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign illegal     = ill_q;
    assign fault       = fault_q;
    assign instr_cnt   = cnt_q;
    assign state       = state_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the per-cycle enables for the PC, IR, ALU, register file, memory port and iterative multiplier. It sits between the instruction register/memory interface and the datapath, and replaces single-cycle use of the combinational control decoder.

## Interface
- MUL_MAX_CYC, 32: cycles MULW waits for mul_done before declaring fault.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  enables instruction processing; sampled in IDLE and at instruction end.
- instr  in  32  current IR contents; valid from DECODE onward.
- mem_ack  in  1  memory completes the current request; valid only while mem_req=1.
- mul_done  in  1  multiplier result ready.
- mem_req  out  1  memory access request, held until mem_ack.
- mem_we  out  1  1=store, 0=read; meaningful only with mem_req.
- pc_we, ir_we  out  1 each  PC increment and IR load strobes.
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL-pass.
- alu_src_imm  out  1  ALU B operand = sign-extended imm[15:0].
- mul_start  out  1  one-cycle multiplier start pulse.
- reg_we  out  1  register-file write strobe.
- reg_dst_rd  out  1  destination select: 1=rd, 0=rt.
- wb_sel_mem  out  1  writeback data select: 1=memory, 0=ALU/MUL.
- busy  out  1  state is neither IDLE nor HALT.
- illegal, fault  out  1 each  sticky error flags.
- instr_cnt  out  16  count of retired instructions, wraps at 0xFFFF→0.
- state  out  3  current state encoding, for debug.

## Operation
- Decode: op=instr[31:26], funct=instr[5:0].
  - op 000001 is R-type. funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 110010 MUL.
  - op 000010 is LOAD rt ← mem[rs+imm].
  - op 000011 is STORE mem[rs+imm] ← rt.
  - Any other op, or any other R-type funct, is illegal.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MULW=4, MEM=5, WB=6, HALT=7.
- IDLE: run=1 → FETCH.
- FETCH: mem_req=1, mem_we=0. On mem_ack, pulse ir_we and pc_we in the same cycle, then → DECODE.
- DECODE: no outputs asserted.
  - Illegal → HALT and set illegal.
  - MUL → MULW.
  - All other instructions → EXEC.
- EXEC: alu_op per funct.
  - LOAD/STORE: alu_op=ADD, alu_src_imm=1, → MEM.
  - R-type: → WB.
- MULW: mul_start=1 in the first MULW cycle only; alu_op=100 throughout.
  - mul_done → WB.
  - After MUL_MAX_CYC cycles without mul_done → HALT and set fault.
  - mul_done in the same cycle as mul_start is accepted.
- MEM: mem_req=1, mem_we=1 for STORE and 0 for LOAD; alu_op=ADD and alu_src_imm=1 held.
  - On mem_ack, LOAD → WB.
  - On mem_ack, STORE retires.
- WB: reg_we=1 for one cycle. reg_dst_rd=1 for R-type. wb_sel_mem=1 for LOAD. The instruction retires.
- Retire: instr_cnt+1. Then → FETCH if run=1, else → IDLE.
- Dropping run mid-instruction does not abort the instruction; it completes and the FSM then goes to IDLE.
- HALT: all strobes 0. Exit is by reset only.
- Reset, including mid-instruction: state=IDLE, every output 0, illegal=fault=0, instr_cnt=0, MULW counter=0.

## Timing
- pc_we, ir_we and the retire in MEM are Mealy outputs qualified by mem_ack. All other outputs are Moore, decoded from state and the latched instr.
- mem_ack may arrive in the same cycle mem_req rises. Each wait cycle adds one cycle.
- Zero-wait latencies, counted from FETCH entry to the next FETCH entry:
  - ADD/SUB/AND/OR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - MUL: 3 + k cycles, where k is MULW cycles up to and including mul_done.
- mem_req never drops before mem_ack. Exactly one ir_we pulse per fetch.
- instr_cnt updates on the cycle after retire.

## Structure
- mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LOAD, OP_STORE;
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_MUL;
  - the alu_op encoding;
  - the state encoding.
- One combinational sub-module, instr_class: decodes instr into {is_rtype, is_load, is_store, is_mul, illegal, alu_op}.
- multicycle_ctrl holds the FSM, the MULW counter and instr_cnt.

## Test plan
- Reset with run=1, mem_ack tied 1, instr=0x04221020 (ADD) → states 1,2,3,6 repeat; reg_we and reg_dst_rd pulse on every 4th cycle; alu_op=000; instr_cnt=3 after 12 cycles.
- instr=0x08A01900 (LOAD), mem_ack delayed 2 cycles in MEM → mem_req held 3 MEM cycles with mem_we=0, then WB with wb_sel_mem=1, reg_dst_rd=0.
- instr=0x0C0A1CFF (STORE) → MEM with mem_we=1, then FETCH with no reg_we; instr_cnt increments.
- instr=0x04015032 (MUL), mul_done after 5 cycles → one mul_start pulse then WB. A second run without mul_done → HALT, fault=1 after 32 MULW cycles.
- instr=0x04430025 (funct 100101) → alu_op=011. Then instr=0xFC000000 → HALT with illegal=1; both illegal and fault clear on reset_n low.
- run dropped during MEM of a LOAD → LOAD completes WB, then IDLE, busy=0; run reasserted → FETCH next cycle.
